mem_burst_arbiter: RTL and testbench
====================================

// Module: mem_burst_arbiter
// PURPOSE
//  Four-channel round-robin arbiter upstream of the DDR burst engine. Channels 0-1 are write
//  masters (video capture), channels 2-3 are read masters (video output). One burst is in
//  flight at a time; it runs from grant to the engine's finish pulse. The arbiter drives the
//  engine's rd/wr burst request port and steers data and handshakes to and from the granted channel.
// PARAMETERS
//  MEM_DATA_BITS  64  data width, equal to the engine's
//  ADDR_BITS      24  burst start address width, equal to the engine's
// PORTS
//  mem_clk          in   1       single clock, shared with the engine
//  rst_n            in   1       asynchronous, active-low reset
//  wrN_req          in   1       N=0,1: write burst request; held high until wrN_finish
//  wrN_len          in   10      burst length in beats; stable while wrN_req is high
//  wrN_addr         in   ADDR    burst start address; stable while wrN_req is high
//  wrN_data_req     out  1       channel must present the next beat on wrN_data in the same cycle
//  wrN_data         in   MEMD    write data
//  wrN_finish       out  1       one-cycle pulse: this channel's burst is complete
//  rdN_req/len/addr in   1/10/A  N=0,1: read request group, same rules as the write group
//  rdN_data_valid   out  1       read beat valid for this channel
//  rdN_data         out  MEMD    read data, broadcast to both read channels
//  rdN_finish       out  1       one-cycle completion pulse
//  rd_burst_req     out  1       to engine
//  wr_burst_req     out  1       to engine
//  rd/wr_burst_len  out  10      to engine, registered
//  rd/wr_burst_addr out  ADDR    to engine, registered
//  wr_burst_data    out  MEMD    to engine, muxed from the granted write channel
//  wr_burst_data_req in  1       from engine
//  rd_burst_data_valid in 1      from engine
//  rd_burst_data    in   MEMD    from engine
//  rd_burst_finish  in   1       from engine
//  wr_burst_finish  in   1       from engine
// BEHAVIOUR
//  Reset values: all outputs 0; state=ARB; rr_ptr=0 (channel 0 has the highest priority first).
//  Channel index order: 0=wr0, 1=wr1, 2=rd0, 3=rd1.
//  A channel is eligible only when its req=1 and its len!=0. A zero-length request is never
//    granted and never receives a finish pulse.
//  ARB: if any channel is eligible, pick the first eligible index at or after rr_ptr (mod 4).
//    On that edge: latch grant[1:0], latch len and addr into the engine-side registers, and set
//    rd_burst_req or wr_burst_req to 1. Go to BUSY. Request-to-engine latency is 1 cycle.
//  BUSY: the engine-side req stays high. The arbiter waits for the finish that matches the
//    granted direction: rd_burst_finish if grant>=2, otherwise wr_burst_finish.
//    On that edge: clear the engine req (it is 0 on the same edge the engine returns to idle),
//    set rr_ptr = grant+1 (mod 4), go to ARB.
//    The minimum gap between bursts is therefore 1 ARB cycle.
//  Finish inputs from the non-granted direction are ignored. A finish in ARB is also ignored.
//  Steering (combinational, gated by state==BUSY and grant):
//    - wrN_data_req = wr_burst_data_req only for the granted write channel.
//    - wr_burst_data = wrN_data of the granted write channel; 0 when no write channel is granted.
//    - rdN_data_valid = rd_burst_data_valid only for the granted read channel.
//    - xxN_finish = the engine finish, for the granted channel only.
//  A channel that drops req mid-burst is a protocol violation. The burst completes regardless.
//  A new request arriving in BUSY waits. Requests that are simultaneous in ARB are resolved by rr_ptr.
//  Reset mid-burst returns the arbiter to ARB at once. The engine is reset by the same rst_n.
// STRUCTURE
//  Shared package: channel index constants CH_WR0..CH_RD1, NUM_CH=4, state encodings ARB/BUSY.
//  One sub-module: rr_pick4 (combinational: 4-bit eligible mask + 2-bit ptr -> grant index + valid).
// TESTING
//  1 Only wr0 requests, len=8, addr=0x100 -> wr_burst_req rises 1 cycle later;
//    exactly 8 wr0_data_req pulses; one wr0_finish; wr_burst_req is 0 on the finish edge.
//  2 All four request at once, len=4 each -> grants in order wr0,wr1,rd0,rd1; each burst is
//    followed by exactly one ARB gap cycle; each channel gets one finish.
//  3 rd1 requests with len=0 while rd0 requests with len=2 -> only rd0 is granted;
//    rd1 never gets a finish; rr_ptr becomes 3.
//  4 Read burst on rd0, len=6 -> rd0_data_valid pulses 6 times; rd1_data_valid stays 0;
//    a spurious wr_burst_finish during BUSY is ignored.
//  5 wr1 continuously re-requests while rd0 waits -> rd0 is granted after at most one wr1 burst.
//  6 rst_n asserted mid-burst (after 3 of 8 beats) -> all outputs 0 asynchronously;
//    after release the state is ARB, rr_ptr=0, and a pending request is granted cleanly.

Source files
------------

// File: rtl/mem_burst_arbiter_pkg.sv
// Shared definitions for the four-channel DDR burst arbiter: channel indices,
// request length width and arbiter state encodings.
package mem_burst_arbiter_pkg;

    localparam int NUM_CH   = 4;
    localparam int LEN_BITS = 10;

    // Channel index order; bit 1 set means a read channel.
    localparam logic [1:0] CH_WR0 = 2'd0;
    localparam logic [1:0] CH_WR1 = 2'd1;
    localparam logic [1:0] CH_RD0 = 2'd2;
    localparam logic [1:0] CH_RD1 = 2'd3;

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic is_read_ch(input logic [1:0] ch);
        return ch[1];
    endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_pick4.sv
// Round-robin picker: first eligible channel at or after ptr, wrapping modulo 4.
module rr_pick4
    import mem_burst_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] eligible,
    input  logic [1:0]        ptr,
    output logic [1:0]        grant,
    output logic              valid
);

    logic [1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned and no latch is inferred.
        grant = ptr;
        valid = 1'b0;
        idx   = ptr;
        // Scan from the farthest offset down so the closest eligible index wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (eligible[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Four-channel round-robin arbiter (wr0, wr1, rd0, rd1) in front of the DDR burst engine;
// one burst in flight, from grant until the engine's matching finish pulse.
module mem_burst_arbiter
    import mem_burst_arbiter_pkg::*;
#(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,

    input  logic                     wr0_req,
    input  logic [LEN_BITS-1:0]      wr0_len,
    input  logic [ADDR_BITS-1:0]     wr0_addr,
    output logic                     wr0_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr0_data,
    output logic                     wr0_finish,

    input  logic                     wr1_req,
    input  logic [LEN_BITS-1:0]      wr1_len,
    input  logic [ADDR_BITS-1:0]     wr1_addr,
    output logic                     wr1_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr1_data,
    output logic                     wr1_finish,

    input  logic                     rd0_req,
    input  logic [LEN_BITS-1:0]      rd0_len,
    input  logic [ADDR_BITS-1:0]     rd0_addr,
    output logic                     rd0_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd0_data,
    output logic                     rd0_finish,

    input  logic                     rd1_req,
    input  logic [LEN_BITS-1:0]      rd1_len,
    input  logic [ADDR_BITS-1:0]     rd1_addr,
    output logic                     rd1_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd1_data,
    output logic                     rd1_finish,

    output logic                     rd_burst_req,
    output logic                     wr_burst_req,
    output logic [LEN_BITS-1:0]      rd_burst_len,
    output logic [LEN_BITS-1:0]      wr_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_data_req,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    input  logic                     wr_burst_finish
);

    arb_state_t           state;
    logic [1:0]           grant;
    logic [1:0]           rr_ptr;
    logic [1:0]           pick;
    logic                 pick_valid;
    logic [NUM_CH-1:0]    eligible;
    logic [LEN_BITS-1:0]  ch_len  [NUM_CH];
    logic [ADDR_BITS-1:0] ch_addr [NUM_CH];
    logic                 busy;
    logic                 done;

    assign ch_len[CH_WR0]  = wr0_len;
    assign ch_len[CH_WR1]  = wr1_len;
    assign ch_len[CH_RD0]  = rd0_len;
    assign ch_len[CH_RD1]  = rd1_len;
    assign ch_addr[CH_WR0] = wr0_addr;
    assign ch_addr[CH_WR1] = wr1_addr;
    assign ch_addr[CH_RD0] = rd0_addr;
    assign ch_addr[CH_RD1] = rd1_addr;

    // Zero-length requests are never eligible, so they never get a grant or a finish.
    assign eligible = {rd1_req && (rd1_len != '0), rd0_req && (rd0_len != '0),
                       wr1_req && (wr1_len != '0), wr0_req && (wr0_len != '0)};

    rr_pick4 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .grant    (pick),
        .valid    (pick_valid)
    );

    assign busy = (state == BUSY);
    // Only the finish matching the granted direction ends the burst.
    assign done = busy && (is_read_ch(grant) ? rd_burst_finish : wr_burst_finish);

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ARB;
            grant         <= CH_WR0;
            rr_ptr        <= CH_WR0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_len  <= '0;
            wr_burst_len  <= '0;
            rd_burst_addr <= '0;
            wr_burst_addr <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values.
            case (state)
                ARB: begin
                    if (pick_valid) begin
                        grant <= pick;
                        state <= BUSY;
                        if (is_read_ch(pick)) begin
                            rd_burst_req  <= 1'b1;
                            rd_burst_len  <= ch_len[pick];
                            rd_burst_addr <= ch_addr[pick];
                        end else begin
                            wr_burst_req  <= 1'b1;
                            wr_burst_len  <= ch_len[pick];
                            wr_burst_addr <= ch_addr[pick];
                        end
                    end
                end
                BUSY: begin
                    if (done) begin
                        rd_burst_req <= 1'b0;
                        wr_burst_req <= 1'b0;
                        rr_ptr       <= grant + 2'd1;
                        state        <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign wr0_data_req   = busy && (grant == CH_WR0) && wr_burst_data_req;
    assign wr1_data_req   = busy && (grant == CH_WR1) && wr_burst_data_req;
    assign rd0_data_valid = busy && (grant == CH_RD0) && rd_burst_data_valid;
    assign rd1_data_valid = busy && (grant == CH_RD1) && rd_burst_data_valid;

    assign wr0_finish = busy && (grant == CH_WR0) && wr_burst_finish;
    assign wr1_finish = busy && (grant == CH_WR1) && wr_burst_finish;
    assign rd0_finish = busy && (grant == CH_RD0) && rd_burst_finish;
    assign rd1_finish = busy && (grant == CH_RD1) && rd_burst_finish;

    assign wr_burst_data = (busy && grant == CH_WR0) ? wr0_data :
                           (busy && grant == CH_WR1) ? wr1_data : '0;

    assign rd0_data = rd_burst_data;
    assign rd1_data = rd_burst_data;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: a behavioural burst engine, a finish scoreboard,
// a table of single-channel bursts and hand-written multi-channel and reset sequences.
`timescale 1ns/1ps
module tb_mem_burst_arbiter;

    localparam logic [63:0] WR0_PAT = 64'hA0A0_1111_2222_00A0;
    localparam logic [63:0] WR1_PAT = 64'hB1B1_3333_4444_00B1;
    localparam logic [63:0] RD_BASE = 64'h5500_0000_0000_0000;

    logic        mem_clk = 1'b0;
    logic        rst_n   = 1'b1;
    always #5 mem_clk = ~mem_clk;

    logic        ch_req  [4];
    logic [9:0]  ch_len  [4];
    logic [23:0] ch_addr [4];
    logic [63:0] wr0_data, wr1_data;

    logic        wr0_data_req, wr1_data_req, rd0_data_valid, rd1_data_valid;
    logic        wr0_finish, wr1_finish, rd0_finish, rd1_finish;
    logic [63:0] rd0_data, rd1_data;
    logic        rd_burst_req, wr_burst_req;
    logic [9:0]  rd_burst_len, wr_burst_len;
    logic [23:0] rd_burst_addr, wr_burst_addr;
    logic [63:0] wr_burst_data;
    logic        wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish;
    logic [63:0] rd_burst_data;

    mem_burst_arbiter #(.MEM_DATA_BITS(64), .ADDR_BITS(24)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .wr0_req(ch_req[0]), .wr0_len(ch_len[0]), .wr0_addr(ch_addr[0]),
        .wr0_data_req(wr0_data_req), .wr0_data(wr0_data), .wr0_finish(wr0_finish),
        .wr1_req(ch_req[1]), .wr1_len(ch_len[1]), .wr1_addr(ch_addr[1]),
        .wr1_data_req(wr1_data_req), .wr1_data(wr1_data), .wr1_finish(wr1_finish),
        .rd0_req(ch_req[2]), .rd0_len(ch_len[2]), .rd0_addr(ch_addr[2]),
        .rd0_data_valid(rd0_data_valid), .rd0_data(rd0_data), .rd0_finish(rd0_finish),
        .rd1_req(ch_req[3]), .rd1_len(ch_len[3]), .rd1_addr(ch_addr[3]),
        .rd1_data_valid(rd1_data_valid), .rd1_data(rd1_data), .rd1_finish(rd1_finish),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
    );

    typedef struct {
        int ch;
        int len;
    } exp_t;

    typedef struct {
        int          ch;
        logic [9:0]  len;
        logic [23:0] addr;
        bit          spur;
        logic        exp_wr_req;
        logic        exp_rd_req;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt[4];
    bit   hold[4];
    bit   spur_en = 1'b0;
    bit   gap_check_en = 1'b0;
    bit   after_fin = 1'b0;
    bit   prev_req = 1'b0;
    bit   prev_fin = 1'b0;
    int   idle_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Burst engine: starts on a seen request, one beat per cycle, then a finish pulse.
    initial begin : engine
        bit busy_e;
        bit is_wr;
        int left;
        int beat;
        busy_e = 1'b0; is_wr = 1'b0; left = 0; beat = 0;
        wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0; rd_burst_data = '0;
        wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
        forever begin
            @(negedge mem_clk);
            wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0; rd_burst_data = '0;
            wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
            if (!rst_n) begin
                busy_e = 1'b0;
            end else if (!busy_e) begin
                if (wr_burst_req) begin
                    busy_e = 1'b1; is_wr = 1'b1; left = int'(wr_burst_len); beat = 0;
                end else if (rd_burst_req) begin
                    busy_e = 1'b1; is_wr = 1'b0; left = int'(rd_burst_len); beat = 0;
                end
            end else if (left > 0) begin
                if (is_wr) begin
                    wr_burst_data_req = 1'b1;
                end else begin
                    rd_burst_data_valid = 1'b1;
                    rd_burst_data = RD_BASE + 64'(beat);
                end
                if (spur_en && !is_wr && beat == 2) wr_burst_finish = 1'b1;
                left--;
                beat++;
            end else begin
                if (is_wr) wr_burst_finish = 1'b1;
                else       rd_burst_finish = 1'b1;
                busy_e = 1'b0;
            end
        end
    end

    task automatic sample();
        logic [3:0] fin_v;
        logic [3:0] beat_v;
        logic       cur_req;
        exp_t       e;
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) cnt[c] = 0;
            prev_req = 1'b0; prev_fin = 1'b0; idle_run = 0;
            return;
        end
        fin_v  = {rd1_finish, rd0_finish, wr1_finish, wr0_finish};
        beat_v = {rd1_data_valid, rd0_data_valid, wr1_data_req, wr0_data_req};
        if (wr0_data_req)   check("wr0 data steering", wr_burst_data, WR0_PAT);
        if (wr1_data_req)   check("wr1 data steering", wr_burst_data, WR1_PAT);
        if (rd0_data_valid) check("rd0 data", rd0_data, RD_BASE + 64'(cnt[2]));
        if (rd1_data_valid) check("rd1 data", rd1_data, RD_BASE + 64'(cnt[3]));
        for (int c = 0; c < 4; c++) if (beat_v[c]) cnt[c]++;
        if (prev_fin) check("engine req low after finish", {62'b0, rd_burst_req, wr_burst_req}, 64'd0);
        cur_req = rd_burst_req | wr_burst_req;
        if (cur_req && !prev_req) begin
            if (gap_check_en && after_fin) check("ARB gap cycles", 64'(idle_run), 64'd1);
            after_fin = 1'b0;
        end
        idle_run = cur_req ? 0 : idle_run + 1;
        prev_req = cur_req;
        for (int c = 0; c < 4; c++) begin
            if (fin_v[c]) begin
                check($sformatf("ch%0d finish expected", c), 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("finish channel", 64'(c), 64'(e.ch));
                    check($sformatf("ch%0d beat count", c), 64'(cnt[c]), 64'(e.len));
                end
                cnt[c] = 0;
                if (!hold[c]) ch_req[c] = 1'b0;
                after_fin = 1'b1;
            end
        end
        prev_fin = |fin_v;
    endtask

    task automatic step();
        @(negedge mem_clk);
        #1;
        sample();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || rd_burst_req || wr_burst_req) && n < budget) begin
            step();
            n++;
        end
        check({name, " drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic request(input int c, input logic [9:0] len, input logic [23:0] addr);
        ch_len[c]  = len;
        ch_addr[c] = addr;
        ch_req[c]  = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " engine req/len"}, 64'({rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len}), 64'd0);
        check({tag, " engine addr"}, 64'({rd_burst_addr, wr_burst_addr}), 64'd0);
        check({tag, " wr_burst_data"}, wr_burst_data, 64'd0);
        check({tag, " channel strobes"}, 64'({wr0_data_req, wr1_data_req, rd0_data_valid, rd1_data_valid,
                                             wr0_finish, wr1_finish, rd0_finish, rd1_finish}), 64'd0);
        check({tag, " read data"}, rd0_data | rd1_data, 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        int n;
        // Single-channel bursts; the last entry is rd1 so the pointer wraps back to 0.
        vecs[0] = '{ch: 0, len: 10'd8,    addr: 24'h000100, spur: 1'b0, exp_wr_req: 1'b1, exp_rd_req: 1'b0};
        vecs[1] = '{ch: 2, len: 10'd6,    addr: 24'h002000, spur: 1'b1, exp_wr_req: 1'b0, exp_rd_req: 1'b1};
        vecs[2] = '{ch: 1, len: 10'd1,    addr: 24'hFFFFFF, spur: 1'b0, exp_wr_req: 1'b1, exp_rd_req: 1'b0};
        vecs[3] = '{ch: 0, len: 10'h3FF,  addr: 24'hABCDEF, spur: 1'b0, exp_wr_req: 1'b1, exp_rd_req: 1'b0};
        vecs[4] = '{ch: 2, len: 10'd1,    addr: 24'h000000, spur: 1'b0, exp_wr_req: 1'b0, exp_rd_req: 1'b1};
        vecs[5] = '{ch: 3, len: 10'd3,    addr: 24'h000001, spur: 1'b0, exp_wr_req: 1'b0, exp_rd_req: 1'b1};

        for (int c = 0; c < 4; c++) begin
            ch_req[c] = 1'b0; ch_len[c] = '0; ch_addr[c] = '0; hold[c] = 1'b0; cnt[c] = 0;
        end
        wr0_data = WR0_PAT;
        wr1_data = WR1_PAT;

        #2 rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            spur_en = vecs[v].spur;
            request(vecs[v].ch, vecs[v].len, vecs[v].addr);
            sb_q.push_back('{ch: vecs[v].ch, len: int'(vecs[v].len)});
            step();
            check($sformatf("v%0d wr_burst_req", v), 64'(wr_burst_req), 64'(vecs[v].exp_wr_req));
            check($sformatf("v%0d rd_burst_req", v), 64'(rd_burst_req), 64'(vecs[v].exp_rd_req));
            check($sformatf("v%0d burst len", v),
                  64'(vecs[v].exp_rd_req ? rd_burst_len : wr_burst_len), 64'(vecs[v].len));
            check($sformatf("v%0d burst addr", v),
                  64'(vecs[v].exp_rd_req ? rd_burst_addr : wr_burst_addr), 64'(vecs[v].addr));
            drain($sformatf("v%0d", v), 2000);
            spur_en = 1'b0;
        end

        // All four at once with the pointer at 0: wr0, wr1, rd0, rd1, one ARB cycle between.
        gap_check_en = 1'b1;
        after_fin = 1'b0;
        for (int c = 0; c < 4; c++) begin
            request(c, 10'd4, 24'(32'h400 * (c + 1)));
            sb_q.push_back('{ch: c, len: 4});
        end
        drain("all four", 200);
        gap_check_en = 1'b0;

        // Zero-length rd1 is skipped; rd0 wins and the pointer moves to 3.
        request(3, 10'd0, 24'h000333);
        request(2, 10'd2, 24'h000222);
        sb_q.push_back('{ch: 2, len: 2});
        drain("zero-length skip", 100);
        ch_len[3] = 10'd2;
        request(0, 10'd2, 24'h000111);
        sb_q.push_back('{ch: 3, len: 2});
        sb_q.push_back('{ch: 0, len: 2});
        drain("pointer at 3", 100);

        // wr1 keeps requesting; rd0 must be served after at most one wr1 burst.
        hold[1] = 1'b1;
        request(1, 10'd3, 24'h000500);
        sb_q.push_back('{ch: 1, len: 3});
        sb_q.push_back('{ch: 2, len: 2});
        sb_q.push_back('{ch: 1, len: 3});
        n = 0;
        while (!wr_burst_req && n < 10) begin step(); n++; end
        check("t5 wr1 granted", 64'(wr_burst_req), 64'd1);
        request(2, 10'd2, 24'h000600);
        n = 0;
        while (sb_q.size() > 1 && n < 100) begin step(); n++; end
        check("t5 rd0 served before second wr1", 64'(sb_q.size()), 64'd1);
        hold[1] = 1'b0;
        drain("wr1 re-request", 100);

        // Reset three beats into an 8-beat wr0 burst; afterwards wr0 beats rd0 from pointer 0.
        request(0, 10'd8, 24'h000300);
        n = 0;
        while (cnt[0] < 3 && n < 30) begin step(); n++; end
        check("t6 three beats before reset", 64'(cnt[0]), 64'd3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async reset");
        request(2, 10'd2, 24'h000700);
        repeat (2) step();
        rst_n = 1'b1;
        sb_q.push_back('{ch: 0, len: 8});
        sb_q.push_back('{ch: 2, len: 2});
        step();
        check("t6 wr0 granted after reset", 64'({wr_burst_req, rd_burst_req}), 64'b10);
        check("t6 wr addr after reset", 64'(wr_burst_addr), 64'h300);
        drain("after reset", 100);

        for (int c = 0; c < 4; c++) check($sformatf("ch%0d stray beats", c), 64'(cnt[c]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
